packet_check: RTL and testbench
===============================

Name: packet_check

Overview:
- Receive-side companion to the packet generator.
- Sinks an AXI4-Stream of test packets and checks every beat against the same pattern, length and tkeep rules the generator uses.
- Reports packet counts, error counts and sticky error flags.
- Sits at the DCMAC RX client interface, or in loopback directly behind the generator.

Parameters:
- DW, 512, data width in bits; 256 and 512 are legal when DCMAC=1, any multiple of 16 when DCMAC=0.
- DCMAC, 1, 1 = per-segment pattern (128-bit segments carry seg number), 0 = single 16-bit counter replicated.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- packet_count  in  32  packets expected; 0 = unbounded.
- packet_length  in  16  bytes per packet, must be >= 1.
- initial_value  in  16  expected data0 of first beat.
- start  in  1  arm the checker (pulse).
- busy  out  1  start | (state != IDLE).
- axis_in_tdata  in  DW  stream data.
- axis_in_tkeep  in  DW/8  byte enables.
- axis_in_tlast  in  1  end of packet.
- axis_in_tvalid  in  1  beat valid.
- axis_in_tready  out  1  high in RUN state only.
- packets_rcvd  out  32  packets ended by tlast since start.
- err_count  out  32  beats with >=1 error, saturating at 0xFFFFFFFF.
- err_flags  out  4  sticky: [0] data, [1] tkeep, [2] early tlast, [3] missing tlast.
- first_err_packet  out  32  packet number (1-based) of first erroring beat; 0 = none.

Behaviour:
- Reset (sync, active-high, wins over everything):
  - state = IDLE; tready = 0.
  - packets_rcvd, err_count, err_flags, first_err_packet = 0.
- States: IDLE, RUN.
- IDLE:
  - On start with packet_length != 0: latch config; exp = initial_value; cycle = 1; packet_number = 1; clear all counters and flags; go to RUN next cycle.
  - start with packet_length == 0 is ignored.
- RUN:
  - axis_in_tready = 1 every cycle.
  - start is ignored.
  - Only handshake cycles (tvalid & tready) are evaluated.
- Length arithmetic, 16-bit:
  - whole = packet_length >> log2(DW/8); partial = packet_length & (DW/8 - 1).
  - total = whole + (partial != 0).
  - exp_keep = all-ones, except on beat cycle == total when partial != 0, where it is (1 << partial) - 1.
- Expected data:
  - DCMAC=0: {DW/16{exp}}.
  - DCMAC=1: segment k (bits 128k+127:128k) = {8{exp+k}}.
  - All adds modulo 2^16.
- Per-handshake checks, evaluated combinationally and registered in the same cycle:
  - data_err: any byte with exp_keep bit set differs from the expected byte. Bytes outside exp_keep are not checked.
  - keep_err: axis_in_tkeep != exp_keep.
  - early_err: tlast & (cycle < total).
  - missing_err: !tlast & (cycle == total). Flagged once per packet. Beats beyond total have exp_keep = all-ones and do not re-flag missing_err.
- On any error in the beat:
  - err_count += 1 (saturating).
  - OR the errors into err_flags.
  - If first_err_packet == 0, load it with packet_number.
- Every handshake: exp += (DCMAC ? DW/128 : 1); cycle += 1 (saturate at 0xFFFF).
- Packet boundary is the received tlast. On tlast:
  - cycle = 1; packets_rcvd += 1.
  - If packet_count != 0 and packet_number == packet_count, go to IDLE next cycle (tready drops). Otherwise packet_number += 1.
- Idle gaps (tvalid low) between or within packets are legal and carry no penalty.
- Results hold in IDLE until the next start or reset.
- Reset mid-packet: immediate return to IDLE with everything cleared; partial packet discarded.

Test Plan:
1. DW=512, DCMAC=1, length=100, count=1, init=0x0010, clean stream.
   -> Beat 1 segs 0x0010..0x0013; beat 2 tkeep 0x0000000FFFFFFFFF, segs 0x0014..0x0017.
   -> packets_rcvd=1, err_flags=0, busy low one cycle after last handshake.
2. count=3, length=64, clean, 5 idle cycles between packets and tvalid gaps inside packets.
   -> packets_rcvd=3, err_count=0, tready low after 3rd tlast.
3. Same as scenario 2, byte 17 of packet 2 beat 1 flipped.
   -> err_flags=0b0001, err_count=1, first_err_packet=2, packets_rcvd=3.
4. length=200 (4 beats expected), tlast on beat 3 of packet 1, then a correct packet.
   -> err_flags[2]=1, err_count=1, packet 2 clean since exp continues incrementing, packets_rcvd=2.
5. length=128, tlast withheld on beat 2, asserted on beat 3.
   -> missing_err once, err_count=1, flags 0b1000, cycle resyncs.
6. init=0xFFFE, DCMAC=1, DW=512.
   -> Segs 0xFFFE, 0xFFFF, 0x0000, 0x0001 accepted without error.
   -> Reset asserted mid-packet: next cycle tready=0, all outputs 0, busy=0.

Source files
------------

// File: rtl/packet_check.sv
// packet_check: receive-side checker for generated AXI4-Stream test packets.
// Checks the data pattern, tkeep and tlast position of every accepted beat
// against the rules the generator uses. It counts packets and erroring beats,
// keeps sticky error flags, and records the first packet that had an error.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   packet_count        packets expected (0 = unbounded)
//   packet_length       bytes per packet (0 = start ignored)
//   initial_value       expected 16-bit pattern value of the first beat
//   start               arm pulse; accepted in IDLE only
//   busy                start | running
//   axis_in_*           AXI4-Stream sink; tready is high while running
//   packets_rcvd        packets closed by tlast since start
//   err_count           beats with at least one error (saturating)
//   err_flags           sticky {missing tlast, early tlast, tkeep, data}
//   first_err_packet    1-based packet number of first bad beat, 0 = none
module packet_check #(
   parameter int unsigned DW    = 512,
   parameter int unsigned DCMAC = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       packet_count,
   input  logic [15:0]       packet_length,
   input  logic [15:0]       initial_value,
   input  logic              start,
   output logic              busy,
   input  logic [DW-1:0]     axis_in_tdata,
   input  logic [DW/8-1:0]   axis_in_tkeep,
   input  logic              axis_in_tlast,
   input  logic              axis_in_tvalid,
   output logic              axis_in_tready,
   output logic [31:0]       packets_rcvd,
   output logic [31:0]       err_count,
   output logic [3:0]        err_flags,
   output logic [31:0]       first_err_packet
);

   localparam int unsigned KB      = DW / 8;
   localparam int unsigned KW      = $clog2(KB);
   localparam int unsigned NHW     = DW / 16;
   localparam int unsigned EXP_INC = (DCMAC != 0) ? DW / 128 : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] pkt_count_q, pkt_count_d;
   logic [15:0] total_q, total_d;
   logic [15:0] partial_q, partial_d;
   logic [15:0] exp_q, exp_d;
   logic [15:0] cycle_q, cycle_d;
   logic [31:0] pkt_num_q, pkt_num_d;
   logic [31:0] packets_rcvd_q, packets_rcvd_d;
   logic [31:0] err_count_q, err_count_d;
   logic [3:0]  err_flags_q, err_flags_d;
   logic [31:0] first_err_q, first_err_d;

   logic [15:0]   len_whole_c;
   logic [15:0]   len_part_c;
   logic [KB-1:0] exp_keep_c;
   logic [DW-1:0] exp_data_c;
   logic          data_err_c;
   logic          keep_err_c;
   logic          early_err_c;
   logic          missing_err_c;
   logic [3:0]    beat_err_c;
   logic          hs_c;

   // Beats per packet derived from the byte length presented with start.
   assign len_whole_c = packet_length >> KW;
   assign len_part_c  = packet_length & 16'(KB - 1);

   assign hs_c = axis_in_tvalid && (state_q == RUN);

   // Expected byte enables: only the final beat of a partial packet is trimmed.
   always_comb begin
      exp_keep_c = '1;
      if ((partial_q != 16'd0) && (cycle_q == total_q)) begin
         for (int b = 0; b < KB; b++) begin
            exp_keep_c[b] = (16'(b) < partial_q);
         end
      end
   end

   // Expected pattern; in segment mode each 128-bit segment carries exp + segment index.
   always_comb begin
      exp_data_c = '0;
      for (int h = 0; h < NHW; h++) begin
         if (DCMAC != 0) begin
            exp_data_c[16*h +: 16] = exp_q + 16'(h / 8);
         end else begin
            exp_data_c[16*h +: 16] = exp_q;
         end
      end
   end

   // Per-beat error classification; bytes outside the expected keep are don't-care.
   always_comb begin
      data_err_c = 1'b0;
      for (int b = 0; b < KB; b++) begin
         if (exp_keep_c[b] && (axis_in_tdata[8*b +: 8] != exp_data_c[8*b +: 8])) begin
            data_err_c = 1'b1;
         end
      end
      keep_err_c    = (axis_in_tkeep != exp_keep_c);
      early_err_c   = axis_in_tlast && (cycle_q < total_q);
      missing_err_c = !axis_in_tlast && (cycle_q == total_q);
      beat_err_c    = {missing_err_c, early_err_c, keep_err_c, data_err_c};
   end

   // Next-state logic for the FSM, counters and result registers.
   always_comb begin
      state_d        = state_q;
      pkt_count_d    = pkt_count_q;
      total_d        = total_q;
      partial_d      = partial_q;
      exp_d          = exp_q;
      cycle_d        = cycle_q;
      pkt_num_d      = pkt_num_q;
      packets_rcvd_d = packets_rcvd_q;
      err_count_d    = err_count_q;
      err_flags_d    = err_flags_q;
      first_err_d    = first_err_q;

      case (state_q)
         IDLE: begin
            if (start && (packet_length != 16'd0)) begin
               state_d        = RUN;
               pkt_count_d    = packet_count;
               total_d        = len_whole_c + 16'(len_part_c != 16'd0);
               partial_d      = len_part_c;
               exp_d          = initial_value;
               cycle_d        = 16'd1;
               pkt_num_d      = 32'd1;
               packets_rcvd_d = 32'd0;
               err_count_d    = 32'd0;
               err_flags_d    = 4'd0;
               first_err_d    = 32'd0;
            end
         end
         RUN: begin
            if (hs_c) begin
               if (beat_err_c != 4'd0) begin
                  if (err_count_q != 32'hFFFF_FFFF) begin
                     err_count_d = err_count_q + 32'd1;
                  end
                  err_flags_d = err_flags_q | beat_err_c;
                  if (first_err_q == 32'd0) begin
                     first_err_d = pkt_num_q;
                  end
               end
               exp_d = exp_q + 16'(EXP_INC);
               if (cycle_q != 16'hFFFF) begin
                  cycle_d = cycle_q + 16'd1;
               end
               // The received tlast defines the packet boundary, right or wrong.
               if (axis_in_tlast) begin
                  cycle_d        = 16'd1;
                  packets_rcvd_d = packets_rcvd_q + 32'd1;
                  if ((pkt_count_q != 32'd0) && (pkt_num_q == pkt_count_q)) begin
                     state_d = IDLE;
                  end else begin
                     pkt_num_d = pkt_num_q + 32'd1;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         pkt_count_q    <= 32'd0;
         total_q        <= 16'd0;
         partial_q      <= 16'd0;
         exp_q          <= 16'd0;
         cycle_q        <= 16'd1;
         pkt_num_q      <= 32'd1;
         packets_rcvd_q <= 32'd0;
         err_count_q    <= 32'd0;
         err_flags_q    <= 4'd0;
         first_err_q    <= 32'd0;
      end else begin
         state_q        <= state_d;
         pkt_count_q    <= pkt_count_d;
         total_q        <= total_d;
         partial_q      <= partial_d;
         exp_q          <= exp_d;
         cycle_q        <= cycle_d;
         pkt_num_q      <= pkt_num_d;
         packets_rcvd_q <= packets_rcvd_d;
         err_count_q    <= err_count_d;
         err_flags_q    <= err_flags_d;
         first_err_q    <= first_err_d;
      end
   end

   assign busy             = start || (state_q != IDLE);
   assign axis_in_tready   = (state_q == RUN);
   assign packets_rcvd     = packets_rcvd_q;
   assign err_count        = err_count_q;
   assign err_flags        = err_flags_q;
   assign first_err_packet = first_err_q;

endmodule

// File: tb/tb_packet_check.sv
// tb_packet_check: randomized and directed stimulus for packet_check, with a
// byte-level reference model checked against the DUT every cycle.
module tb_packet_check;

   localparam int unsigned DW = 512;
   localparam int unsigned KB = DW / 8;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [31:0]     packet_count = '0;
   logic [15:0]     packet_length = '0;
   logic [15:0]     initial_value = '0;
   logic            start = 1'b0;
   logic            busy;
   logic [DW-1:0]   axis_in_tdata = '0;
   logic [KB-1:0]   axis_in_tkeep = '0;
   logic            axis_in_tlast = 1'b0;
   logic            axis_in_tvalid = 1'b0;
   logic            axis_in_tready;
   logic [31:0]     packets_rcvd;
   logic [31:0]     err_count;
   logic [3:0]      err_flags;
   logic [31:0]     first_err_packet;

   int total_n = 0;
   int bad_n   = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   packet_check #(.DW(DW), .DCMAC(1)) dut (
      .clk(clk), .reset(reset),
      .packet_count(packet_count), .packet_length(packet_length),
      .initial_value(initial_value), .start(start), .busy(busy),
      .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep),
      .axis_in_tlast(axis_in_tlast), .axis_in_tvalid(axis_in_tvalid),
      .axis_in_tready(axis_in_tready), .packets_rcvd(packets_rcvd),
      .err_count(err_count), .err_flags(err_flags),
      .first_err_packet(first_err_packet)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pattern byte b of a beat whose first segment value is e (segment = 16 bytes).
   function automatic logic [7:0] exp_byte(input int e, input int b);
      int v;
      v = (e + b / 16) % 65536;
      return (b % 2 == 1) ? 8'(v >> 8) : 8'(v);
   endfunction

   // Bytes a correct beat n of an len-byte packet carries.
   function automatic int keep_bytes(input int len, input int n);
      int total;
      total = (len + KB - 1) / KB;
      return (n == total) ? len - (total - 1) * KB : KB;
   endfunction

   // ---------------- reference model ----------------
   bit          m_run = 1'b0;
   int          m_len = 0;
   logic [31:0] m_cnt = '0;
   int          m_exp = 0;
   int          m_beat = 1;
   logic [31:0] m_pnum = '0, m_rcvd = '0, m_errc = '0, m_first = '0;
   logic [3:0]  m_flags = '0;

   always @(posedge clk) begin
      if (reset) begin
         m_run = 1'b0; m_rcvd = '0; m_errc = '0; m_flags = '0; m_first = '0;
      end else if (!m_run) begin
         if (start && packet_length != 16'd0) begin
            m_run = 1'b1; m_len = int'(packet_length); m_cnt = packet_count;
            m_exp = int'(initial_value); m_beat = 1; m_pnum = 32'd1;
            m_rcvd = '0; m_errc = '0; m_flags = '0; m_first = '0;
         end
      end else if (axis_in_tvalid) begin
         int total, nb;
         logic [3:0] e;
         total = (m_len + KB - 1) / KB;
         nb = keep_bytes(m_len, m_beat);
         e = '0;
         for (int b = 0; b < nb; b++)
            if (axis_in_tdata[8*b +: 8] != exp_byte(m_exp, b)) e[0] = 1'b1;
         for (int b = 0; b < KB; b++)
            if (axis_in_tkeep[b] != (b < nb)) e[1] = 1'b1;
         e[2] = axis_in_tlast && (m_beat < total);
         e[3] = !axis_in_tlast && (m_beat == total);
         if (e != 4'd0) begin
            if (m_errc != 32'hFFFF_FFFF) m_errc = m_errc + 1;
            m_flags = m_flags | e;
            if (m_first == 0) m_first = m_pnum;
         end
         m_exp = (m_exp + DW / 128) % 65536;
         m_beat++;
         if (axis_in_tlast) begin
            m_beat = 1;
            m_rcvd = m_rcvd + 1;
            if (m_cnt != 0 && m_pnum == m_cnt) m_run = 1'b0;
            else m_pnum = m_pnum + 1;
         end
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("tready", 32'(axis_in_tready), 32'(m_run));
         check("busy", 32'(busy), 32'(start | m_run));
         check("packets_rcvd", packets_rcvd, m_rcvd);
         check("err_count", err_count, m_errc);
         check("err_flags", 32'(err_flags), 32'(m_flags));
         check("first_err_packet", first_err_packet, m_first);
      end
   end

   // ---------------- driver ----------------
   int d_exp = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic arm(input int cnt, input int len, input int init);
      packet_count  = 32'(cnt);
      packet_length = 16'(len);
      initial_value = 16'(init);
      d_exp = init % 65536;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [KB-1:0] k, input logic last);
      int guard;
      axis_in_tdata  = d;
      axis_in_tkeep  = k;
      axis_in_tlast  = last;
      axis_in_tvalid = 1'b1;
      guard = 0;
      while (!axis_in_tready && guard < 20) begin
         step();
         guard++;
      end
      if (!axis_in_tready) check("tready_timeout", 32'(axis_in_tready), 32'd1);
      step();
      axis_in_tvalid = 1'b0;
      axis_in_tlast  = 1'b0;
      d_exp = (d_exp + DW / 128) % 65536;
   endtask

   // mode: 0 clean, 1 data flip in keep, 2 tkeep error, 3 early tlast,
   // 4 late tlast, 5 flip a byte outside keep (must not count as error).
   // fbeat/fbyte pin the error position (0 = random); for modes 3/4 fbeat is the tlast beat.
   task automatic send_packet(input int len, input int mode, input int gap_max,
                              input int fbeat, input int fbyte);
      int total, nbeats, eb, nb, md;
      logic [DW-1:0] d;
      logic [KB-1:0] k;
      total = (len + KB - 1) / KB;
      md = mode;
      if (md == 3 && total < 2) md = 0;
      nbeats = total;
      if (md == 3) nbeats = (fbeat > 0) ? fbeat : $urandom_range(1, total - 1);
      if (md == 4) nbeats = (fbeat > 0) ? fbeat : total + $urandom_range(1, 2);
      eb = (fbeat > 0) ? fbeat : $urandom_range(1, nbeats);
      for (int n = 1; n <= nbeats; n++) begin
         repeat ($urandom_range(0, gap_max)) step();
         nb = (n > total) ? KB : keep_bytes(len, n);
         for (int b = 0; b < KB; b++) begin
            k[b] = (b < nb);
            d[8*b +: 8] = exp_byte(d_exp, b);
         end
         if (md == 1 && n == eb) begin
            int fb;
            fb = (fbyte >= 0 && fbeat > 0) ? fbyte : $urandom_range(0, nb - 1);
            d[8*fb +: 8] = d[8*fb +: 8] ^ 8'h01;
         end
         if (md == 2 && n == eb) k[$urandom_range(0, KB - 1)] ^= 1'b1;
         if (md == 5 && n == total && nb < KB) begin
            int fb;
            fb = $urandom_range(nb, KB - 1);
            d[8*fb +: 8] = ~d[8*fb +: 8];
         end
         send_beat(d, k, n == nbeats);
      end
   endtask

   initial begin
      int cnt, len, mode, sel;
      repeat (3) step();
      reset = 1'b0;
      chk_en = 1'b1;
      check("rst_tready", 32'(axis_in_tready), 32'd0);
      check("rst_rcvd", packets_rcvd, 32'd0);

      // Pattern pins for the model's byte function.
      check("pin_seg1_lo", 32'(exp_byte(16'h0010, 16)), 32'h11);
      check("pin_wrap_seg2", 32'(exp_byte(16'hFFFE, 33)), 32'h00);
      check("pin_keep_100_2", 32'(keep_bytes(100, 2)), 32'd36);

      // 1: single 100-byte packet.
      arm(1, 100, 16'h0010);
      send_packet(100, 0, 0, 0, 0);
      check("s1_tready", 32'(axis_in_tready), 32'd0);
      check("s1_busy", 32'(busy), 32'd0);
      check("s1_rcvd", packets_rcvd, 32'd1);
      check("s1_flags", 32'(err_flags), 32'd0);
      repeat (2) step();

      // Zero length start ignored.
      arm(1, 0, 16'h0000);
      step();
      check("len0_tready", 32'(axis_in_tready), 32'd0);

      // 2: three clean 64-byte packets with gaps.
      arm(3, 64, 16'h1234);
      for (int p = 0; p < 3; p++) begin
         send_packet(64, 0, 2, 0, 0);
         if (p < 2) repeat (5) step();
      end
      check("s2_rcvd", packets_rcvd, 32'd3);
      check("s2_errc", err_count, 32'd0);
      check("s2_tready", 32'(axis_in_tready), 32'd0);
      repeat (2) step();

      // 3: byte 17 of packet 2 beat 1 flipped.
      arm(3, 64, 16'h0100);
      send_packet(64, 0, 2, 0, 0);
      repeat (5) step();
      send_packet(64, 1, 2, 1, 17);
      repeat (5) step();
      send_packet(64, 0, 2, 0, 0);
      check("s3_flags", 32'(err_flags), 32'd1);
      check("s3_errc", err_count, 32'd1);
      check("s3_first", first_err_packet, 32'd2);
      check("s3_rcvd", packets_rcvd, 32'd3);
      repeat (2) step();

      // 4: early tlast on beat 3 of a 4-beat packet, then a clean one.
      arm(2, 200, 16'h0500);
      send_packet(200, 3, 0, 3, 0);
      send_packet(200, 0, 1, 0, 0);
      check("s4_flags", 32'(err_flags), 32'b0100);
      check("s4_errc", err_count, 32'd1);
      check("s4_rcvd", packets_rcvd, 32'd2);
      repeat (2) step();

      // 5: tlast withheld on beat 2, given on beat 3; then a clean packet.
      arm(2, 128, 16'h0700);
      send_packet(128, 4, 0, 3, 0);
      send_packet(128, 0, 0, 0, 0);
      check("s5_flags", 32'(err_flags), 32'b1000);
      check("s5_errc", err_count, 32'd1);
      check("s5_rcvd", packets_rcvd, 32'd2);
      repeat (2) step();

      // 6: pattern wrap, then reset in the middle of an unbounded run.
      arm(1, 200, 16'hFFFE);
      send_packet(200, 0, 0, 0, 0);
      check("s6_flags", 32'(err_flags), 32'd0);
      arm(0, 300, 16'h2000);
      send_packet(300, 2, 0, 0, 0);
      send_packet(300, 0, 0, 0, 0);
      begin
         logic [DW-1:0] d;
         for (int b = 0; b < KB; b++) d[8*b +: 8] = exp_byte(d_exp, b);
         send_beat(d, '1, 1'b0);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("s6_tready", 32'(axis_in_tready), 32'd0);
      check("s6_busy", 32'(busy), 32'd0);
      check("s6_rcvd", packets_rcvd, 32'd0);
      check("s6_errc", err_count, 32'd0);
      check("s6_flags_rst", 32'(err_flags), 32'd0);
      check("s6_first", first_err_packet, 32'd0);
      step();

      // Randomized runs.
      for (int r = 0; r < 25; r++) begin
         cnt = $urandom_range(1, 4);
         len = $urandom_range(1, 300);
         arm(cnt, len, int'($urandom_range(0, 65535)));
         for (int p = 0; p < cnt; p++) begin
            sel = $urandom_range(0, 11);
            mode = (sel < 6) ? 0 : sel - 6;
            send_packet(len, mode, 2, 0, 0);
            repeat ($urandom_range(0, 3)) step();
         end
         repeat (2) step();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule
